// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow from operand and result sign bits.
  function automatic logic signed_ovf(input logic op_sel,
                                      input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb);
    logic same_sign_in;
    same_sign_in = (a_msb == b_msb);
    if (op_sel == OP_ADD) begin
      return same_sign_in && (r_msb != a_msb);
    end
    return !same_sign_in && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_add_sub_unit_bit_cell.sv
// One-bit full adder / full subtractor cell used for every serial step.
module addsub_bit_cell
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin_bin,
  input  logic sel,
  output logic sum_diff,
  output logic cout_bout
);

  logic a_xor_b;

  always_comb begin
    a_xor_b  = a ^ b;
    sum_diff = a_xor_b ^ cin_bin;
    if (sel == OP_SUB) begin
      // Borrow when b plus incoming borrow exceeds a.
      cout_bout = (~a & b) | (~a_xor_b & cin_bin);
    end else begin
      cout_bout = (a & b) | (a_xor_b & cin_bin);
    end
  end

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Signed overflow flag is built only when SERIAL_ADD_SUB_OVF_EN is defined.
module serial_add_sub_unit
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_bout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             sel_q,    sel_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic cell_a;
  logic cell_b;
  logic cell_sum;
  logic cell_cout;
  logic last_bit;

  always_comb begin
    cell_a   = a_q[cnt_q];
    cell_b   = b_q[cnt_q];
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  addsub_bit_cell u_cell (
    .a         (cell_a),
    .b         (cell_b),
    .cin_bin   (carry_q),
    .sel       (sel_q),
    .sum_diff  (cell_sum),
    .cout_bout (cell_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      SHIFT: begin
        result_d = {cell_sum, result_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          cout_d  = cell_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout_bout = cout_q;

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow is judged on the step that produces the result MSB.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == SHIFT) && last_bit) begin
      ovf_d = signed_ovf(sel_q, a_q[WIDTH-1], b_q[WIDTH-1], cell_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for serial_add_sub_unit (WIDTH=8).
module tb_serial_add_sub_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout_bout;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  serial_add_sub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout_bout (cout_bout),
    .overflow  (overflow)
  );

  // Reference: wide unsigned arithmetic for result/carry, signed range for overflow.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    int         sx;
    int         sy;
    int         r;
    exp_t       e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s == 1'b0) begin
      t = {1'b0, x} + {1'b0, y};
      r = sx + sy;
    end else begin
      t = {1'b0, x} - {1'b0, y};
      r = sx - sy;
    end
    e.res = t[W-1:0];
    e.co  = t[W];
`ifdef SERIAL_ADD_SUB_OVF_EN
    e.ov  = (r > 127) || (r < -128);
`else
    e.ov  = 1'b0;
`endif
    return e;
  endfunction

  // Drive one start request, then scramble the operand inputs.
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    a     = x;
    b     = y;
    exp_q.push_back(model(s, x, y));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sel   = 1'($urandom);
  endtask

  // Returns the index of the edge that samples done high, counted from the last edge seen.
  task automatic wait_done(output bit ok, output int edges);
    ok    = 1'b0;
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        ok    = 1'b1;
        edges = k + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t got;
    bit   ok;
    int   edges;
    rst = 1'b1; start = 1'b0; sel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, result, cout_bout, overflow} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h co=%b ov=%b want all zero",
               busy, done, result, cout_bout, overflow);
    end
    start = 1'b1; a = 8'h12; b = 8'h34; sel = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_priority: got busy=%b want 0", busy);
    end
    rst = 1'b0;
    exp_q.push_back(model(1'b0, 8'h12, 8'h34));
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_start_accept: got busy=%b want 1", busy);
    end
    wait_done(ok, edges);
    tests_run++;
    if (!ok || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL first_op_timeout: got done=%b want 1", done);
    end else begin
      e   = exp_q.pop_front();
      got = '{res: result, co: cout_bout, ov: overflow};
      if (got !== e) begin
        tests_failed++;
        $display("FAIL first_op_result: got res=%h co=%b ov=%b want res=%h co=%b ov=%b",
                 got.res, got.co, got.ov, e.res, e.co, e.ov);
      end
    end
  endtask

  task automatic test_add();
    logic [W-1:0] xa[3] = '{8'h35, 8'hFF, 8'h7F};
    logic [W-1:0] xb[3] = '{8'h4A, 8'h01, 8'h01};
    exp_t e;
    exp_t got;
    bit   ok;
    int   edges;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, xa[i], xb[i]);
      wait_done(ok, edges);
      tests_run++;
      if (!ok || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL add_timeout[%0d]: got no done pulse, want one", i);
        continue;
      end
      e   = exp_q.pop_front();
      got = '{res: result, co: cout_bout, ov: overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL add[%0d]: got res=%h co=%b ov=%b want res=%h co=%b ov=%b",
                 i, got.res, got.co, got.ov, e.res, e.co, e.ov);
      end
      tests_run++;
      if (edges !== 9 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL add_latency[%0d]: got edges=%0d busy=%b want edges=9 busy=1", i, edges, busy);
      end
      repeat (3) @(negedge clk);
      got = '{res: result, co: cout_bout, ov: overflow};
      tests_run++;
      if (got !== e || done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL add_hold[%0d]: got res=%h co=%b ov=%b done=%b busy=%b want res=%h co=%b ov=%b done=0 busy=0",
                 i, got.res, got.co, got.ov, done, busy, e.res, e.co, e.ov);
      end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] xa[2] = '{8'h10, 8'h80};
    logic [W-1:0] xb[2] = '{8'h20, 8'h01};
    exp_t e;
    exp_t got;
    bit   ok;
    int   edges;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, xa[i], xb[i]);
      wait_done(ok, edges);
      tests_run++;
      if (!ok || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sub_timeout[%0d]: got no done pulse, want one", i);
        continue;
      end
      e   = exp_q.pop_front();
      got = '{res: result, co: cout_bout, ov: overflow};
      tests_run++;
      if (got !== e || edges !== 9) begin
        tests_failed++;
        $display("FAIL sub[%0d]: got res=%h bo=%b ov=%b edges=%0d want res=%h bo=%b ov=%b edges=9",
                 i, got.res, got.co, got.ov, edges, e.res, e.co, e.ov);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    exp_t got;
    bit   ok;
    int   edges;
    int   pulses;
    issue(1'b0, 8'h35, 8'h4A);
    repeat (2) @(negedge clk);
    start = 1'b1; sel = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignore_busy: got busy=%b want 1", busy);
    end
    wait_done(ok, edges);
    tests_run++;
    if (!ok || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL ignore_timeout: got no done pulse, want one");
      return;
    end
    e   = exp_q.pop_front();
    got = '{res: result, co: cout_bout, ov: overflow};
    tests_run++;
    if (got !== e || edges !== 6) begin
      tests_failed++;
      $display("FAIL ignore_result: got res=%h co=%b ov=%b edges=%0d want res=%h co=%b ov=%b edges=6",
               got.res, got.co, got.ov, edges, e.res, e.co, e.ov);
    end
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_no_queue: got extra_done=%0d busy=%b want 0 and 0", pulses, busy);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    issue(1'b0, 8'h35, 8'h4A);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0 || cout_bout !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: got busy=%b res=%h done=%b co=%b want 0 00 0 0",
               busy, result, done, cout_bout);
    end
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got done_pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    exp_t         got;
    bit           ok;
    int           edges;
    logic         s;
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      issue(s, x, y);
      wait_done(ok, edges);
      tests_run++;
      if (!ok || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL b2b_timeout[%0d]: got no done pulse, want one", i);
        continue;
      end
      e   = exp_q.pop_front();
      got = '{res: result, co: cout_bout, ov: overflow};
      if (got !== e || edges !== 9) begin
        tests_failed++;
        $display("FAIL b2b[%0d] sel=%b a=%h b=%h: got res=%h co=%b ov=%b edges=%0d want res=%h co=%b ov=%b edges=9",
                 i, s, x, y, got.res, got.co, got.ov, edges, e.res, e.co, e.ov);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_unit.md
SERIAL_ADD_SUB_UNIT -- requirements
Module: serial_add_sub_unit

Interface
REQ-001 The parameter SHALL be: WIDTH, default 8, operand and result width in bits (>= 2).
REQ-002 The ports SHALL be, in order:
  clk  input  1  rising-edge clock.
  rst  input  1  synchronous active-high reset.
  start  input  1  request to begin an operation, sampled on the rising edge.
  sel  input  1  operation select: 0 = add, 1 = subtract; captured with start.
  a  input  WIDTH  minuend or first addend; captured with start.
  b  input  WIDTH  subtrahend or second addend; captured with start.
  busy  output  1  high while an operation is in progress.
  done  output  1  one-cycle completion pulse.
  result  output  WIDTH  sum or difference, modulo 2^WIDTH.
  cout_bout  output  1  final carry-out (add) or borrow-out (subtract).
  overflow  output  1  signed two's-complement overflow flag.
REQ-003 The block SHALL use one clock, clk, and a reset, rst, that is synchronous and active-high.

Function
REQ-004 The block SHALL compute a+b or a-b bit-serially, LSB first, with one bit per clk cycle through a 1-bit full adder/subtractor cell.
REQ-005 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-006 IDLE→SHIFT SHALL occur on start=1; on that edge a, b and sel are latched, the bit counter is set to 0, and the carry/borrow flop is set to 0.
REQ-007 In SHIFT, each edge SHALL:
  - feed operand bit i and the carry/borrow flop into the cell;
  - shift the cell's sum/diff bit into result bit i;
  - load the cell's cout/bout into the carry/borrow flop;
  - increment the counter.
REQ-008 SHIFT→DONE SHALL occur on the edge that processes bit WIDTH-1.
REQ-009 DONE→IDLE SHALL occur unconditionally on the next edge.
REQ-010 done SHALL be high only in DONE, exactly WIDTH+1 edges after the edge that sampled start.
REQ-011 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-012 start SHALL be ignored in SHIFT and in DONE; there is no queuing.
REQ-013 An input change on a, b or sel during SHIFT SHALL NOT affect the operation in progress.
REQ-014 result, cout_bout and overflow SHALL be stable and valid from the DONE cycle until the next accepted start.
REQ-015 result, cout_bout and overflow MAY change while busy=1.
REQ-016 For subtraction, cout_bout=1 SHALL indicate unsigned a<b, and result SHALL equal (a-b) mod 2^WIDTH.
REQ-017 The addition carry-in SHALL be 0, and the subtraction borrow-in SHALL be 0.

Reset
REQ-018 When rst=1 at an edge, the block SHALL enter IDLE and clear result, cout_bout, overflow, done, busy, the counter and all internal operand and carry registers to 0.
REQ-019 rst SHALL take priority over start.
REQ-020 A reset mid-SHIFT SHALL abort the operation with no done pulse.
REQ-021 The first start SHALL be accepted on the first edge with rst=0.

Configuration
REQ-022 The overflow feature SHALL be controlled by the macro SERIAL_ADD_SUB_OVF_EN.
REQ-023 With SERIAL_ADD_SUB_OVF_EN defined, overflow SHALL be registered in DONE as follows:
  - add: (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]);
  - subtract: (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
REQ-024 With SERIAL_ADD_SUB_OVF_EN undefined, the overflow port SHALL remain present, be tied to 0, and have no overflow logic synthesized.

Structure
REQ-025 A shared package, serial_add_sub_pkg, SHALL hold:
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the op-select constants OP_ADD=1'b0 and OP_SUB=1'b1.
REQ-026 The 1-bit combinational cell SHALL be a single sub-module, addsub_bit_cell, with ports a, b, cin_bin, sel, sum_diff and cout_bout, instantiated once.
REQ-027 The counter width SHALL be $clog2(WIDTH).
REQ-028 Unused state encodings SHALL recover to IDLE.

Verification (WIDTH=8, OVF_EN defined)
REQ-029 Add 8'h35+8'h4A: after start, result=8'h7F, cout_bout=0, overflow=0, with done exactly 9 edges after start.
REQ-030 Add 8'hFF+8'h01: result=8'h00, cout_bout=1, overflow=0.
REQ-031 Add 8'h7F+8'h01: result=8'h80, cout_bout=0, overflow=1.
REQ-032 Subtract 8'h10-8'h20: result=8'hF0, cout_bout=1, overflow=0.
REQ-033 Subtract 8'h80-8'h01: result=8'h7F, cout_bout=0, overflow=1.
REQ-034 Start an add, then:
  - pulse start with new operands at edge 3: it is ignored and the first result is intact;
  - assert rst at edge 5: busy=0 and result=0 next cycle, and no done pulse is produced.
